// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the SRAM arbiter.
//   state_e   - arbiter FSM states
//   grant_e   - which master owns the current access
//   ERR_RDATA - read data returned for an aborted (timed-out) access
//   CNT_W     - width of the REQ timeout counter (TIMEOUT up to 65535)
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IFU = 1'b0,
    GNT_LSU = 1'b1
  } grant_e;

  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;
  localparam int unsigned CNT_W     = 16;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: valid/ready memory port shared by IFU, LSU and the SRAM.
//   valid/addr/wdata/wmask/wen - request from the master side
//   ready/rdata                - one-cycle completion and read data back
//   master modport drives the request; slave modport answers it.
interface sram_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic                  valid;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wmask;
  logic                  wen;
  logic                  ready;
  logic [DATA_W-1:0]     rdata;

  modport master (output valid, addr, wdata, wmask, wen, input ready, rdata);
  modport slave  (input valid, addr, wdata, wmask, wen, output ready, rdata);

endinterface

// File: rtl/sram_arb_pick.sv
// sram_arb_pick: combinational grant selection between IFU and LSU.
//   ifu_valid_i/lsu_valid_i - pending requests
//   last_grant_i            - master granted most recently
//   grant_c_o               - winner (meaningful only when any_req_c_o)
//   any_req_c_o             - at least one request pending
module sram_arb_pick
  import sram_arb_pkg::*;
#(
  parameter int unsigned LSU_PRIO = 1
) (
  input  logic   ifu_valid_i,
  input  logic   lsu_valid_i,
  input  grant_e last_grant_i,
  output grant_e grant_c_o,
  output logic   any_req_c_o
);

  // Ties go to the LSU in priority mode, otherwise to whoever lost last time.
  always_comb begin
    grant_c_o = GNT_IFU;
    if (ifu_valid_i && lsu_valid_i) begin
      if (LSU_PRIO != 0) begin
        grant_c_o = GNT_LSU;
      end else if (last_grant_i == GNT_LSU) begin
        grant_c_o = GNT_IFU;
      end else begin
        grant_c_o = GNT_LSU;
      end
    end else if (lsu_valid_i) begin
      grant_c_o = GNT_LSU;
    end
  end

  assign any_req_c_o = ifu_valid_i | lsu_valid_i;

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM port between the IFU (read-only) and LSU.
//   clk, rst - clock and asynchronous active-high reset
//   ifu      - IFU read port (slave side; write fields are ignored)
//   lsu      - LSU read/write port (slave side)
//   sram     - registered request toward the SRAM (master side)
//   bus_err  - pulses with the master ready of a timed-out access
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LSU_PRIO = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  ifu,
  sram_arbiter_if.slave  lsu,
  sram_arbiter_if.master sram,
  output logic           bus_err
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  grant_e              grant_q, grant_d;
  grant_e              last_q, last_d;
  grant_e              pick_grant;
  logic                pick_any;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sram_valid_q, sram_valid_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic                wen_q, wen_d;
  logic                ifu_ready_q, ifu_ready_d;
  logic                lsu_ready_q, lsu_ready_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d;
  logic [DATA_W-1:0]   lsu_rdata_q, lsu_rdata_d;
  logic                bus_err_q, bus_err_d;
  logic [DATA_W-1:0]   rdata_n;

  sram_arb_pick #(
    .LSU_PRIO (LSU_PRIO)
  ) u_pick (
    .ifu_valid_i  (ifu.valid),
    .lsu_valid_i  (lsu.valid),
    .last_grant_i (last_q),
    .grant_c_o    (pick_grant),
    .any_req_c_o  (pick_any)
  );

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    sram_valid_d = sram_valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    wen_d        = wen_q;
    ifu_ready_d  = 1'b0;
    lsu_ready_d  = 1'b0;
    ifu_rdata_d  = ifu_rdata_q;
    lsu_rdata_d  = lsu_rdata_q;
    bus_err_d    = 1'b0;
    rdata_n      = sram.rdata;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d      = pick_grant;
          last_d       = pick_grant;
          cnt_d        = '0;
          sram_valid_d = 1'b1;
          state_d      = REQ;
          if (pick_grant == GNT_LSU) begin
            addr_d  = lsu.addr;
            wdata_d = lsu.wdata;
            wmask_d = lsu.wmask;
            wen_d   = lsu.wen;
          end else begin
            // IFU is read-only: never let it write
            addr_d  = ifu.addr;
            wdata_d = '0;
            wmask_d = '0;
            wen_d   = 1'b0;
          end
        end
      end
      REQ: begin
        // Completion wins over a timeout landing in the same cycle
        if (sram.ready || (cnt_q == CNT_LAST)) begin
          rdata_n      = sram.ready ? sram.rdata : DATA_W'(ERR_RDATA);
          bus_err_d    = ~sram.ready;
          sram_valid_d = 1'b0;
          state_d      = RESP;
          if (grant_q == GNT_LSU) begin
            lsu_ready_d = 1'b1;
            lsu_rdata_d = rdata_n;
          end else begin
            ifu_ready_d = 1'b1;
            ifu_rdata_d = rdata_n;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d      = IDLE;
        sram_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= GNT_IFU;
      last_q       <= GNT_LSU;
      cnt_q        <= '0;
      sram_valid_q <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      wen_q        <= 1'b0;
      ifu_ready_q  <= 1'b0;
      lsu_ready_q  <= 1'b0;
      ifu_rdata_q  <= '0;
      lsu_rdata_q  <= '0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      sram_valid_q <= sram_valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      wen_q        <= wen_d;
      ifu_ready_q  <= ifu_ready_d;
      lsu_ready_q  <= lsu_ready_d;
      ifu_rdata_q  <= ifu_rdata_d;
      lsu_rdata_q  <= lsu_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign sram.valid = sram_valid_q;
  assign sram.addr  = addr_q;
  assign sram.wdata = wdata_q;
  assign sram.wmask = wmask_q;
  assign sram.wen   = wen_q;
  assign ifu.ready  = ifu_ready_q;
  assign ifu.rdata  = ifu_rdata_q;
  assign lsu.ready  = lsu_ready_q;
  assign lsu.rdata  = lsu_rdata_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed bench for sram_arbiter.
//   dut   - round-robin, TIMEOUT=4, behavioural SRAM with settable latency/stall
//   dut_p - LSU priority, same master stimulus, zero-latency SRAM
module tb_sram_arbiter;

  logic clk;
  logic rst;
  logic bus_err_m;
  logic bus_err_p;

  int checks = 0;
  int errors = 0;

  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_m ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_m ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) sram_m ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifu_p ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) lsu_p ();
  sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) sram_p ();

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(0), .TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .ifu     (ifu_m),
    .lsu     (lsu_m),
    .sram    (sram_m),
    .bus_err (bus_err_m)
  );

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .LSU_PRIO(1), .TIMEOUT(4)) dut_p (
    .clk     (clk),
    .rst     (rst),
    .ifu     (ifu_p),
    .lsu     (lsu_p),
    .sram    (sram_p),
    .bus_err (bus_err_p)
  );

  // Priority instance mirrors the master requests; its SRAM answers at once.
  assign ifu_p.valid  = ifu_m.valid;
  assign ifu_p.addr   = ifu_m.addr;
  assign ifu_p.wdata  = ifu_m.wdata;
  assign ifu_p.wmask  = ifu_m.wmask;
  assign ifu_p.wen    = ifu_m.wen;
  assign lsu_p.valid  = lsu_m.valid;
  assign lsu_p.addr   = lsu_m.addr;
  assign lsu_p.wdata  = lsu_m.wdata;
  assign lsu_p.wmask  = lsu_m.wmask;
  assign lsu_p.wen    = lsu_m.wen;
  assign sram_p.ready = sram_p.valid;
  assign sram_p.rdata = 32'h0;

  // Behavioural SRAM: 16 words selected by addr[13:10], ready after lat wait cycles.
  logic [31:0] mem [0:15];
  int unsigned sw_q;
  int unsigned lat;
  bit          stall;

  assign sram_m.ready = sram_m.valid && !stall && (sw_q >= lat);
  assign sram_m.rdata = mem[sram_m.addr[13:10]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h0010_0073;
      sw_q   <= 0;
    end else begin
      if (!sram_m.valid || sram_m.ready) sw_q <= 0;
      else sw_q <= sw_q + 1;
      if (sram_m.valid && sram_m.ready && sram_m.wen) begin
        for (int b = 0; b < 4; b++)
          if (sram_m.wmask[b]) mem[sram_m.addr[13:10]][8*b +: 8] <= sram_m.wdata[8*b +: 8];
      end
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int       pulses;
  int       accs;
  bit       dbl;
  logic     prev;
  logic [3:0] hist_m;
  logic [3:0] hist_p;
  int       n_m;
  int       n_p;

  initial begin
    rst = 1'b1;
    ifu_m.valid = 1'b0; ifu_m.addr = '0; ifu_m.wdata = '0; ifu_m.wmask = '0; ifu_m.wen = 1'b0;
    lsu_m.valid = 1'b0; lsu_m.addr = '0; lsu_m.wdata = '0; lsu_m.wmask = '0; lsu_m.wen = 1'b0;
    lat = 0;
    stall = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_sram_valid", 64'(sram_m.valid), 64'd0);
    chk("rst_sram_addr",  64'(sram_m.addr), 64'd0);
    chk("rst_ifu_ready",  64'(ifu_m.ready), 64'd0);
    chk("rst_lsu_ready",  64'(lsu_m.ready), 64'd0);
    chk("rst_bus_err",    64'(bus_err_m), 64'd0);
    chk("rst_ifu_rdata",  64'(ifu_m.rdata), 64'd0);
    chk("rst_lsu_rdata",  64'(lsu_m.rdata), 64'd0);
    rst = 1'b0;
    step();

    // Single IFU read, SRAM answers one cycle after sram_valid
    lat = 1;
    ifu_m.valid = 1'b1;
    ifu_m.addr  = 32'h8000_0000;
    step();
    chk("ifu_sram_valid", 64'(sram_m.valid), 64'd1);
    chk("ifu_sram_addr",  64'(sram_m.addr), 64'h8000_0000);
    chk("ifu_sram_wen",   64'(sram_m.wen), 64'd0);
    chk("ifu_sram_wmask", 64'(sram_m.wmask), 64'd0);
    step();
    chk("ifu_wait_valid", 64'(sram_m.valid), 64'd1);
    chk("ifu_wait_ready", 64'(ifu_m.ready), 64'd0);
    step();
    chk("ifu_ready",      64'(ifu_m.ready), 64'd1);
    chk("ifu_rdata",      64'(ifu_m.rdata), 64'h0010_0073);
    chk("ifu_lsu_ready",  64'(lsu_m.ready), 64'd0);
    chk("ifu_resp_valid", 64'(sram_m.valid), 64'd0);
    ifu_m.valid = 1'b0;
    step();
    chk("ifu_ready_drop", 64'(ifu_m.ready), 64'd0);

    // LSU write
    lat = 0;
    lsu_m.valid = 1'b1;
    lsu_m.addr  = 32'h8000_1000;
    lsu_m.wdata = 32'h1234_5678;
    lsu_m.wmask = 4'b1111;
    lsu_m.wen   = 1'b1;
    step();
    chk("wr_sram_valid", 64'(sram_m.valid), 64'd1);
    chk("wr_sram_addr",  64'(sram_m.addr), 64'h8000_1000);
    chk("wr_sram_wdata", 64'(sram_m.wdata), 64'h1234_5678);
    chk("wr_sram_wmask", 64'(sram_m.wmask), 64'hf);
    chk("wr_sram_wen",   64'(sram_m.wen), 64'd1);
    step();
    chk("wr_lsu_ready",  64'(lsu_m.ready), 64'd1);
    chk("wr_ifu_ready",  64'(ifu_m.ready), 64'd0);
    chk("wr_bus_err",    64'(bus_err_m), 64'd0);
    chk("wr_mem",        64'(mem[4]), 64'h1234_5678);
    lsu_m.valid = 1'b0;
    step();
    chk("wr_ready_drop", 64'(lsu_m.ready), 64'd0);

    // Timeout: SRAM never answers
    stall = 1'b1;
    lsu_m.valid = 1'b1;
    lsu_m.addr  = 32'h8000_0000;
    lsu_m.wmask = 4'b0000;
    lsu_m.wen   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_sram_valid", 64'(sram_m.valid), 64'd1);
    end
    step();
    chk("to_valid_drop", 64'(sram_m.valid), 64'd0);
    chk("to_lsu_ready",  64'(lsu_m.ready), 64'd1);
    chk("to_bus_err",    64'(bus_err_m), 64'd1);
    chk("to_lsu_rdata",  64'(lsu_m.rdata), 64'hDEAD_BEEF);
    chk("to_ifu_ready",  64'(ifu_m.ready), 64'd0);
    lsu_m.valid = 1'b0;
    stall = 1'b0;
    step();
    chk("to_err_drop",   64'(bus_err_m), 64'd0);
    chk("to_ready_drop", 64'(lsu_m.ready), 64'd0);

    // Normal read after the abort returns the earlier write
    lsu_m.valid = 1'b1;
    lsu_m.addr  = 32'h8000_1000;
    step();
    step();
    chk("post_to_ready", 64'(lsu_m.ready), 64'd1);
    chk("post_to_err",   64'(bus_err_m), 64'd0);
    chk("post_to_rdata", 64'(lsu_m.rdata), 64'h1234_5678);
    lsu_m.valid = 1'b0;
    step();

    // Reset in the middle of REQ, between clock edges
    stall = 1'b1;
    ifu_m.valid = 1'b1;
    ifu_m.addr  = 32'h8000_0000;
    step();
    chk("mr_req_valid", 64'(sram_m.valid), 64'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("mr_valid_async", 64'(sram_m.valid), 64'd0);
    chk("mr_no_ready",    64'(ifu_m.ready), 64'd0);
    step();
    chk("mr_no_ready_2",  64'(ifu_m.ready), 64'd0);
    stall = 1'b0;
    rst = 1'b0;
    step();
    chk("mr_post_req",    64'(sram_m.valid), 64'd1);
    chk("mr_post_noready", 64'(ifu_m.ready), 64'd0);
    step();
    chk("mr_post_ready",  64'(ifu_m.ready), 64'd1);
    chk("mr_post_rdata",  64'(ifu_m.rdata), 64'h0010_0073);
    ifu_m.valid = 1'b0;
    step();

    // IFU holds valid through RESP for 6 cycles
    ifu_m.valid = 1'b1;
    pulses = 0;
    accs = 0;
    dbl = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ifu_m.ready) pulses++;
      if (ifu_m.ready && prev) dbl = 1'b1;
      prev = ifu_m.ready;
      if (sram_m.valid) accs++;
    end
    ifu_m.valid = 1'b0;
    chk("held_pulses",   64'(pulses), 64'd2);
    chk("held_accesses", 64'(accs), 64'd2);
    chk("held_double",   64'(dbl), 64'd0);
    step();
    step();

    // Four repeated ties from reset: round-robin vs LSU priority
    rst = 1'b1;
    step();
    rst = 1'b0;
    ifu_m.valid = 1'b1;
    ifu_m.addr  = 32'h8000_0000;
    lsu_m.valid = 1'b1;
    lsu_m.addr  = 32'h8000_1000;
    lsu_m.wen   = 1'b0;
    hist_m = '0;
    hist_p = '0;
    n_m = 0;
    n_p = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ifu_m.ready) begin hist_m = {hist_m[2:0], 1'b0}; n_m++; end
      if (lsu_m.ready) begin hist_m = {hist_m[2:0], 1'b1}; n_m++; end
      if (ifu_p.ready) begin hist_p = {hist_p[2:0], 1'b0}; n_p++; end
      if (lsu_p.ready) begin hist_p = {hist_p[2:0], 1'b1}; n_p++; end
    end
    ifu_m.valid = 1'b0;
    lsu_m.valid = 1'b0;
    chk("rr_order",   64'(hist_m), 64'b0101);
    chk("rr_count",   64'(n_m), 64'd4);
    chk("prio_order", 64'(hist_p), 64'b1111);
    chk("prio_count", 64'(n_p), 64'd4);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM slave port between two masters: the IFU (instruction fetch, read-only) and the LSU (load/store, read/write).
- Sits between IFU/LSU and the SRAM model, on the same valid/ready protocol they already use.
- Serialises accesses with a 3-state FSM and registers the payload toward SRAM.
- Returns the SRAM response to the granted master only, and bounds each SRAM wait with a timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; wmask width is DATA_W/8
LSU_PRIO, 1, 1 = LSU wins simultaneous requests; 0 = round-robin
TIMEOUT, 255, maximum cycles in REQ before the access is aborted (1..65535)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
ifu_valid  in  1  IFU read request; payload held stable until ifu_ready
ifu_addr  in  ADDR_W  IFU read address
ifu_ready  out  1  one-cycle response pulse; ifu_rdata valid in that cycle
ifu_rdata  out  DATA_W  IFU read data (registered)
lsu_valid  in  1  LSU request; payload held stable until lsu_ready
lsu_addr  in  ADDR_W  LSU address
lsu_wdata  in  DATA_W  LSU write data
lsu_wmask  in  DATA_W/8  LSU byte enables
lsu_wen  in  1  1 = write, 0 = read
lsu_ready  out  1  one-cycle response pulse
lsu_rdata  out  DATA_W  LSU read data (registered)
sram_valid  out  1  request to SRAM
sram_addr/sram_wdata/sram_wmask/sram_wen  out  ADDR_W/DATA_W/DATA_W/8/1  registered payload
sram_ready  in  1  SRAM completion; sram_rdata valid in that cycle
sram_rdata  in  DATA_W  SRAM read data
bus_err  out  1  one-cycle pulse, coincident with the master ready of an aborted (timed-out) access

Behaviour:
Reset values:
- All outputs 0; state IDLE; timeout counter 0; last_grant = LSU.
- Consequence: IFU wins the first tie in round-robin mode.
- An assertion of rst in any state (including mid-REQ) forces IDLE and drops sram_valid immediately, without waiting for a clock edge.
- No response pulse is issued for an access interrupted by reset.

FSM states: IDLE, REQ, RESP.
- IDLE, no valid: stay in IDLE.
- IDLE, any valid, tie resolved by policy:
  - Latch grant and payload into the sram_* registers.
  - For an IFU grant, force sram_wen = 0 and sram_wmask = 0.
  - Update last_grant; go to REQ.
- REQ: sram_valid = 1 and the payload stays constant.
  - On sram_ready: capture sram_rdata into the granted master's rdata register, then go to RESP.
  - The counter increments every cycle spent in REQ without sram_ready.
  - When the counter reaches TIMEOUT: go to RESP with rdata = 32'hDEADBEEF and bus_err set.
- RESP: the granted master's ready = 1 for exactly one cycle (bus_err too, if aborted); sram_valid = 0; then go to IDLE.
  - Both masters' valid inputs are ignored in RESP.
  - A valid still held high in the following IDLE cycle is a new request.
  - rdata holds its value until the next capture for that master.

Latency and ordering:
- Minimum latency is valid -> ready in 3 cycles: IDLE sample, REQ with same-cycle sram_ready, RESP.
- Back-to-back requests from one master each take at least 3 cycles; there is no pipelining.
- sram_ready outside REQ is ignored.
- A losing requester remains pending; its valid is not consumed.
- With round-robin, the loser wins the next tie, so neither master waits more than one foreign access.
- With LSU_PRIO = 1, the IFU can starve under continuous LSU traffic; this is accepted behaviour.
- For writes, rdata is still updated with sram_rdata (don't-care value).
- The counter resets to 0 on every entry to REQ.

Decomposition:
- Shared package sram_arb_pkg holds:
  - state enum (IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2)
  - grant encoding (GNT_IFU = 1'b0, GNT_LSU = 1'b1)
  - constant ERR_RDATA = 32'hDEADBEEF
- One natural sub-module: sram_arb_pick. It is combinational and takes (ifu_valid, lsu_valid, last_grant, LSU_PRIO) to produce (grant, any_req).

Test Plan:
- Single IFU read: ifu_valid with addr 0x80000000; SRAM returns 0x00100073 one cycle after sram_valid. Required: sram_wen = 0, ifu_ready pulses 1 cycle, ifu_rdata = 0x00100073, lsu_ready stays 0.
- LSU write: addr 0x80001000, wdata 0x12345678, wmask 4'b1111, wen = 1. Required: sram_* carry exactly these values while sram_valid is high; lsu_ready pulses once; SRAM shows the write.
- Simultaneous requests, LSU_PRIO = 0, starting from reset:
  - Grant order is IFU, LSU, IFU, LSU across 4 repeated ties.
  - With LSU_PRIO = 1, all 4 ties go to LSU.
- Timeout, TIMEOUT = 4, sram_ready tied to 0. Required:
  - sram_valid high for exactly 4 cycles, then drops.
  - lsu_ready and bus_err pulse together, with lsu_rdata = 0xDEADBEEF.
  - The next request proceeds normally.
- Reset mid-access: assert rst during REQ, between clock edges. Required:
  - sram_valid = 0 immediately, with no ready pulse.
  - After release, an IFU request completes with the normal 3-cycle latency.
- Held valid: IFU holds ifu_valid through RESP. Required: exactly 2 accesses over 6 cycles, never a double ready pulse in consecutive cycles.
